// File: rtl/qpu_io_pkg.sv
// Shared register map, bit positions and constants for the QPU_V I/O responder.
package qpu_io_pkg;

  localparam logic [3:0] REG_GPIO_OUT   = 4'd0;
  localparam logic [3:0] REG_GPIO_IN    = 4'd1;
  localparam logic [3:0] REG_TMR_RELOAD = 4'd2;
  localparam logic [3:0] REG_TMR_CTRL   = 4'd3;
  localparam logic [3:0] REG_TMR_COUNT  = 4'd4;
  localparam logic [3:0] REG_IRQ_STAT   = 4'd5;
  localparam logic [3:0] REG_IRQ_EN     = 4'd6;
  localparam logic [3:0] REG_PRESCALE   = 4'd7;
  localparam logic [3:0] REG_EDGE_MASK  = 4'd8;
  localparam logic [3:0] REG_WDT_KICK   = 4'd9;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_DONE = 2;

  localparam int STAT_TMR  = 0;
  localparam int STAT_EDGE = 1;

  localparam logic [7:0] WDT_KICK_VAL = 8'h5A;

endpackage

// File: rtl/qpu_io_timer.sv
// Prescaled down-counter: ticks every PRESCALE+1 cycles while enabled, flags expiry at zero.
module qpu_io_timer
  import qpu_io_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic       auto_i,
  input  logic [7:0] presc_i,
  input  logic [7:0] reload_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] count_o,
  output logic       expire_o
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]         count_q, count_d;
  logic               tick;
  logic               expire;

  always_comb begin
    tick        = en_i && (presc_cnt_q == PRESC_W'(presc_i));
    presc_cnt_d = '0;
    if (en_i && !tick) begin
      presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    end

    expire  = tick && (count_q == 8'd0);
    count_d = count_q;
    if (tick) begin
      if (count_q != 8'd0) begin
        count_d = count_q - 8'd1;
      end else if (auto_i) begin
        count_d = reload_i;
      end
    end
    // A CPU write to RELOAD overrides whatever the tick would have done.
    if (load_i) begin
      count_d = load_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt_q <= '0;
      count_q     <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = expire;

endmodule

// File: rtl/qpu_io_responder.sv
// I/O-space responder for QPU_V: GPIO, prescaled timer, IRQ status/enable, IRQ1/IRQ2.
// Optional watchdog on address 9 is built only when QPU_IO_WDT_EN is defined.
module qpu_io_responder
  import qpu_io_pkg::*;
#(
  parameter int          GPIO_W     = 8,
  parameter int          PRESC_W    = 8,
  parameter logic [15:0] WDT_CYCLES = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        M_AddrI,
  input  logic              M_WEI,
  input  logic              M_IOI,
  input  logic [7:0]        W_DinI,
  output logic [7:0]        M_DoutO,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              IRQ1,
  output logic              IRQ2,
  output logic              wdt_rst
);

  logic       sel, wr, rd;
  logic [3:0] reg_addr;

  logic [GPIO_W-1:0] gpio_out_q;
  logic [GPIO_W-1:0] sync1_q, sync2_q, sync_d_q;
  logic [GPIO_W-1:0] edge_mask_q;
  logic [GPIO_W-1:0] rise;
  logic [7:0]        reload_q;
  logic [7:0]        presc_q;
  logic              ctrl_en_q, ctrl_en_d;
  logic              ctrl_auto_q, ctrl_auto_d;
  logic              ctrl_done_q, ctrl_done_d;
  logic [1:0]        stat_q, stat_d;
  logic [1:0]        irq_en_q;
  logic              irq1_q, irq2_q;
  logic              wdt_rst_q;

  logic [7:0]        tmr_count;
  logic              tmr_expire;
  logic [7:0]        rdata;

  logic wr_gpio, wr_reload, wr_ctrl, wr_stat, wr_irq_en, wr_presc, wr_mask;

  assign sel      = M_IOI && (M_AddrI[9:4] == 6'd0);
  assign wr       = sel && M_WEI;
  assign rd       = sel && !M_WEI;
  assign reg_addr = M_AddrI[3:0];

  assign wr_gpio   = wr && (reg_addr == REG_GPIO_OUT);
  assign wr_reload = wr && (reg_addr == REG_TMR_RELOAD);
  assign wr_ctrl   = wr && (reg_addr == REG_TMR_CTRL);
  assign wr_stat   = wr && (reg_addr == REG_IRQ_STAT);
  assign wr_irq_en = wr && (reg_addr == REG_IRQ_EN);
  assign wr_presc  = wr && (reg_addr == REG_PRESCALE);
  assign wr_mask   = wr && (reg_addr == REG_EDGE_MASK);

  qpu_io_timer #(
    .PRESC_W (PRESC_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en_i       (ctrl_en_q),
    .auto_i     (ctrl_auto_q),
    .presc_i    (presc_q),
    .reload_i   (reload_q),
    .load_i     (wr_reload),
    .load_val_i (W_DinI),
    .count_o    (tmr_count),
    .expire_o   (tmr_expire)
  );

  assign rise = sync2_q & ~sync_d_q & edge_mask_q;

  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    ctrl_auto_d = ctrl_auto_q;
    ctrl_done_d = ctrl_done_q;
    if (tmr_expire && !ctrl_auto_q) begin
      ctrl_en_d   = 1'b0;
      ctrl_done_d = 1'b1;
    end
    // The CPU's EN wins over a same-cycle one-shot expiry.
    if (wr_ctrl) begin
      ctrl_en_d   = W_DinI[CTRL_EN];
      ctrl_auto_d = W_DinI[CTRL_AUTO];
      if (W_DinI[CTRL_EN]) begin
        ctrl_done_d = 1'b0;
      end
    end

    // Hardware sets are applied after the W1C so a colliding set survives.
    stat_d = stat_q;
    if (wr_stat) begin
      stat_d = stat_q & ~W_DinI[1:0];
    end
    if (tmr_expire) begin
      stat_d[STAT_TMR] = 1'b1;
    end
    if (|rise) begin
      stat_d[STAT_EDGE] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_d_q    <= '0;
      edge_mask_q <= '0;
      reload_q    <= '0;
      presc_q     <= '0;
      ctrl_en_q   <= 1'b0;
      ctrl_auto_q <= 1'b0;
      ctrl_done_q <= 1'b0;
      stat_q      <= '0;
      irq_en_q    <= '0;
      irq1_q      <= 1'b0;
      irq2_q      <= 1'b0;
    end else begin
      sync1_q     <= gpio_in;
      sync2_q     <= sync1_q;
      sync_d_q    <= sync2_q;
      ctrl_en_q   <= ctrl_en_d;
      ctrl_auto_q <= ctrl_auto_d;
      ctrl_done_q <= ctrl_done_d;
      stat_q      <= stat_d;
      irq1_q      <= stat_q[STAT_TMR] & irq_en_q[0];
      irq2_q      <= stat_q[STAT_EDGE] & irq_en_q[1];
      if (wr_gpio) begin
        gpio_out_q <= W_DinI[GPIO_W-1:0];
      end
      if (wr_reload) begin
        reload_q <= W_DinI;
      end
      if (wr_irq_en) begin
        irq_en_q <= W_DinI[1:0];
      end
      if (wr_presc) begin
        presc_q <= W_DinI;
      end
      if (wr_mask) begin
        edge_mask_q <= W_DinI[GPIO_W-1:0];
      end
    end
  end

`ifdef QPU_IO_WDT_EN
  logic [15:0] wdt_cnt_q;
  logic        wr_kick;

  assign wr_kick = wr && (reg_addr == REG_WDT_KICK);

  // Any kick restarts the count; only the magic value releases a fired watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt_q <= '0;
      wdt_rst_q <= 1'b0;
    end else if (wr_kick) begin
      wdt_cnt_q <= '0;
      if (W_DinI == WDT_KICK_VAL) begin
        wdt_rst_q <= 1'b0;
      end
    end else if (wdt_cnt_q == WDT_CYCLES) begin
      wdt_rst_q <= 1'b1;
    end else begin
      wdt_cnt_q <= wdt_cnt_q + 16'd1;
    end
  end
`else
  logic unused_wdt_cycles;

  assign wdt_rst_q         = 1'b0;
  assign unused_wdt_cycles = ^WDT_CYCLES;
`endif

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (reg_addr)
        REG_GPIO_OUT:   rdata[GPIO_W-1:0] = gpio_out_q;
        REG_GPIO_IN:    rdata[GPIO_W-1:0] = sync2_q;
        REG_TMR_RELOAD: rdata = reload_q;
        REG_TMR_CTRL:   rdata[2:0] = {ctrl_done_q, ctrl_auto_q, ctrl_en_q};
        REG_TMR_COUNT:  rdata = tmr_count;
        REG_IRQ_STAT:   rdata[1:0] = stat_q;
        REG_IRQ_EN:     rdata[1:0] = irq_en_q;
        REG_PRESCALE:   rdata = presc_q;
        REG_EDGE_MASK:  rdata[GPIO_W-1:0] = edge_mask_q;
        REG_WDT_KICK:   rdata[0] = wdt_rst_q;
        default:        rdata = '0;
      endcase
    end
  end

  assign M_DoutO  = rdata;
  assign gpio_out = gpio_out_q;
  assign IRQ1     = irq1_q;
  assign IRQ2     = irq2_q;
  assign wdt_rst  = wdt_rst_q;

endmodule
